// File: rtl/pacman_sprite_render_if.sv
// Pixel-side bundle between the VGA sync counter, the control inputs and the
// Pac-Man sprite renderer.
interface pacman_sprite_render_if;
   logic        p_tick;
   logic [9:0]  p_x;
   logic [9:0]  p_y;
   logic        hs_in;
   logic        vs_in;
   logic        move_en;
   logic [1:0]  dir_in;
   logic [11:0] rgb;
   logic        hs_out;
   logic        vs_out;

   modport master (
      output p_tick, p_x, p_y, hs_in, vs_in, move_en, dir_in,
      input  rgb, hs_out, vs_out
   );

   modport slave (
      input  p_tick, p_x, p_y, hs_in, vs_in, move_en, dir_in,
      output rgb, hs_out, vs_out
   );
endinterface

// File: rtl/pacman_sprite_render.sv
// Three-stage pixel pipeline drawing one chomping Pac-Man disc over a flat
// background; position, heading and mouth update once per frame in blanking.
module pacman_sprite_render #(
   parameter int          H_ACTIVE    = 640,
   parameter int          V_ACTIVE    = 480,
   parameter int          SIZE        = 16,
   parameter int          STEP        = 2,
   parameter int          ANIM_FRAMES = 8,
   parameter int          START_X     = 312,
   parameter int          START_Y     = 232,
   parameter logic [11:0] PAC_COLOR   = 12'hFF0,
   parameter logic [11:0] BG_COLOR    = 12'h000
) (
   input logic                   clk,
   input logic                   rst,
   pacman_sprite_render_if.slave bus
);

   localparam logic signed [10:0] R_S       = 11'(SIZE / 2);
   localparam logic signed [10:0] STEP_S    = 11'(STEP);
   localparam logic signed [10:0] X_MAX_S   = 11'(H_ACTIVE - SIZE);
   localparam logic signed [10:0] Y_MAX_S   = 11'(V_ACTIVE - SIZE);
   localparam logic [21:0]        R_SQ      = 22'((SIZE / 2) * (SIZE / 2));
   localparam logic [7:0]         ANIM_LAST = 8'(ANIM_FRAMES - 1);

   typedef enum logic [1:0] {
      DIR_RIGHT = 2'b00,
      DIR_LEFT  = 2'b01,
      DIR_UP    = 2'b10,
      DIR_DOWN  = 2'b11
   } dir_t;

   typedef enum logic {
      MOUTH_OPEN   = 1'b0,
      MOUTH_CLOSED = 1'b1
   } mouth_t;

   logic                p_tick_d_r;
   logic                en_s;
   logic                frame_evt_s;
   logic [9:0]          pos_x_r, pos_y_r;
   dir_t                dir_r;
   mouth_t              mouth_r;
   logic [7:0]          anim_cnt_r;
   logic signed [10:0]  base_x_s, base_y_s, nx_s, ny_s;
   logic [9:0]          nx_clamp_s, ny_clamp_s;

   logic signed [10:0]  dx1_r, dy1_r;
   logic                active1_r, hs1_r, vs1_r;
   dir_t                dir1_r;
   mouth_t              mouth1_r;

   logic signed [10:0]  abs_dx_s, abs_dy_s;
   logic signed [21:0]  dx_sq_s, dy_sq_s;
   logic [21:0]         dist_s;
   logic                in_disc_s, wedge_s, in_mouth_s;
   logic                in_disc2_r, in_mouth2_r, active2_r, hs2_r, vs2_r;

   logic [11:0]         rgb_next_s;
   logic [11:0]         rgb_r;
   logic                hs_out_r, vs_out_r;

   assign en_s        = bus.p_tick & ~p_tick_d_r;
   assign frame_evt_s = en_s && (bus.p_x == 10'd0) && (bus.p_y == 10'(V_ACTIVE));
   assign base_x_s    = $signed({1'b0, pos_x_r});
   assign base_y_s    = $signed({1'b0, pos_y_r});

   // Pixel-strobe edge detector
   always_ff @(posedge clk) begin
      if (rst) begin
         p_tick_d_r <= 1'b0;
      end else begin
         p_tick_d_r <= bus.p_tick;
      end
   end

   // Candidate next position, stepped along dir_in and saturated at the walls
   always_comb begin
      nx_s = base_x_s;
      ny_s = base_y_s;
      case (bus.dir_in)
         2'b00:   nx_s = base_x_s + STEP_S;
         2'b01:   nx_s = base_x_s - STEP_S;
         2'b10:   ny_s = base_y_s - STEP_S;
         2'b11:   ny_s = base_y_s + STEP_S;
         default: begin
            nx_s = base_x_s;
            ny_s = base_y_s;
         end
      endcase
      if (nx_s < 11'sd0) begin
         nx_clamp_s = 10'd0;
      end else if (nx_s > X_MAX_S) begin
         nx_clamp_s = X_MAX_S[9:0];
      end else begin
         nx_clamp_s = nx_s[9:0];
      end
      if (ny_s < 11'sd0) begin
         ny_clamp_s = 10'd0;
      end else if (ny_s > Y_MAX_S) begin
         ny_clamp_s = Y_MAX_S[9:0];
      end else begin
         ny_clamp_s = ny_s[9:0];
      end
   end

   // Per-frame sprite state: heading always follows dir_in, motion and mouth only when moving
   always_ff @(posedge clk) begin
      if (rst) begin
         pos_x_r    <= 10'(START_X);
         pos_y_r    <= 10'(START_Y);
         dir_r      <= DIR_RIGHT;
         mouth_r    <= MOUTH_OPEN;
         anim_cnt_r <= 8'd0;
      end else if (frame_evt_s) begin
         dir_r <= dir_t'(bus.dir_in);
         if (bus.move_en) begin
            pos_x_r <= nx_clamp_s;
            pos_y_r <= ny_clamp_s;
            if (anim_cnt_r == ANIM_LAST) begin
               anim_cnt_r <= 8'd0;
               mouth_r    <= (mouth_r == MOUTH_OPEN) ? MOUTH_CLOSED : MOUTH_OPEN;
            end else begin
               anim_cnt_r <= anim_cnt_r + 8'd1;
            end
         end
      end
   end

   // Stage 1: offsets from the sprite centre, with the sprite state latched alongside
   always_ff @(posedge clk) begin
      if (rst) begin
         dx1_r     <= 11'sd0;
         dy1_r     <= 11'sd0;
         active1_r <= 1'b0;
         hs1_r     <= 1'b1;
         vs1_r     <= 1'b1;
         dir1_r    <= DIR_RIGHT;
         mouth1_r  <= MOUTH_OPEN;
      end else if (en_s) begin
         dx1_r     <= $signed({1'b0, bus.p_x}) - base_x_s - R_S;
         dy1_r     <= $signed({1'b0, bus.p_y}) - base_y_s - R_S;
         active1_r <= (bus.p_x < 10'(H_ACTIVE)) && (bus.p_y < 10'(V_ACTIVE));
         hs1_r     <= bus.hs_in;
         vs1_r     <= bus.vs_in;
         dir1_r    <= dir_r;
         mouth1_r  <= mouth_r;
      end
   end

   // Disc and mouth-wedge tests on the stage-1 offsets
   always_comb begin
      abs_dx_s = dx1_r[10] ? -dx1_r : dx1_r;
      abs_dy_s = dy1_r[10] ? -dy1_r : dy1_r;
      dx_sq_s  = dx1_r * dx1_r;
      dy_sq_s  = dy1_r * dy1_r;
      dist_s   = $unsigned(dx_sq_s) + $unsigned(dy_sq_s);
      in_disc_s = (dist_s < R_SQ);
      case (dir1_r)
         DIR_RIGHT: wedge_s = (dx1_r > 11'sd0) && (abs_dy_s <= dx1_r);
         DIR_LEFT:  wedge_s = (dx1_r < 11'sd0) && (abs_dy_s <= abs_dx_s);
         DIR_UP:    wedge_s = (dy1_r < 11'sd0) && (abs_dx_s <= abs_dy_s);
         DIR_DOWN:  wedge_s = (dy1_r > 11'sd0) && (abs_dx_s <= dy1_r);
         default:   wedge_s = 1'b0;
      endcase
      in_mouth_s = (mouth1_r == MOUTH_OPEN) && wedge_s;
   end

   // Stage 2 register
   always_ff @(posedge clk) begin
      if (rst) begin
         in_disc2_r  <= 1'b0;
         in_mouth2_r <= 1'b0;
         active2_r   <= 1'b0;
         hs2_r       <= 1'b1;
         vs2_r       <= 1'b1;
      end else if (en_s) begin
         in_disc2_r  <= in_disc_s;
         in_mouth2_r <= in_mouth_s;
         active2_r   <= active1_r;
         hs2_r       <= hs1_r;
         vs2_r       <= vs1_r;
      end
   end

   // Colour select: blanking forces black regardless of background colour
   always_comb begin
      if (!active2_r) begin
         rgb_next_s = 12'h000;
      end else if (in_disc2_r && !in_mouth2_r) begin
         rgb_next_s = PAC_COLOR;
      end else begin
         rgb_next_s = BG_COLOR;
      end
   end

   // Stage 3 output register
   always_ff @(posedge clk) begin
      if (rst) begin
         rgb_r    <= 12'h000;
         hs_out_r <= 1'b1;
         vs_out_r <= 1'b1;
      end else if (en_s) begin
         rgb_r    <= rgb_next_s;
         hs_out_r <= hs2_r;
         vs_out_r <= vs2_r;
      end
   end

   assign bus.rgb    = rgb_r;
   assign bus.hs_out = hs_out_r;
   assign bus.vs_out = vs_out_r;

endmodule

// File: tb/tb_pacman_sprite_render.sv
// Directed plus randomized bench for pacman_sprite_render, checked against a
// geometric model of the sprite and a three-pixel output history.
module tb_pacman_sprite_render;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   // model state
   int          m_x, m_y, m_dir, m_moves;
   logic [11:0] h_rgb [3];
   logic        h_hs  [3];
   logic        h_vs  [3];

   pacman_sprite_render_if bus ();

   pacman_sprite_render dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] exp_rgb(input int x, input int y);
      int  dx, dy, along, across;
      bit  mouth_open;
      if (x >= 640 || y >= 480) return 12'h000;
      dx = x - m_x - 8;
      dy = y - m_y - 8;
      if (dx * dx + dy * dy >= 64) return 12'h000;
      // component of the offset along the heading, and the magnitude across it
      case (m_dir)
         0:       begin along =  dx; across = (dy < 0) ? -dy : dy; end
         1:       begin along = -dx; across = (dy < 0) ? -dy : dy; end
         2:       begin along = -dy; across = (dx < 0) ? -dx : dx; end
         default: begin along =  dy; across = (dx < 0) ? -dx : dx; end
      endcase
      mouth_open = ((m_moves / 8) % 2) == 0;
      if (mouth_open && along > 0 && across <= along) return 12'h000;
      return 12'hFF0;
   endfunction

   task automatic model_reset();
      m_x = 312; m_y = 232; m_dir = 0; m_moves = 0;
      for (int i = 0; i < 3; i++) begin
         h_rgb[i] = 12'h000; h_hs[i] = 1'b1; h_vs[i] = 1'b1;
      end
   endtask

   task automatic model_frame(input bit mv, input int d);
      m_dir = d;
      if (mv) begin
         case (d)
            0:       m_x += 2;
            1:       m_x -= 2;
            2:       m_y -= 2;
            default: m_y += 2;
         endcase
         m_x = (m_x < 0) ? 0 : ((m_x > 624) ? 624 : m_x);
         m_y = (m_y < 0) ? 0 : ((m_y > 464) ? 464 : m_y);
         m_moves++;
      end
   endtask

   // one pixel period (4 clks, p_tick high for 2); starts and ends on a negedge
   task automatic pixel(input int x, input int y, input bit hs, input bit vs,
                        input bit mv, input int d);
      bus.p_x     = 10'(x);
      bus.p_y     = 10'(y);
      bus.hs_in   = hs;
      bus.vs_in   = vs;
      bus.move_en = mv;
      bus.dir_in  = 2'(d);
      bus.p_tick  = 1'b1;
      h_rgb[2] = h_rgb[1]; h_hs[2] = h_hs[1]; h_vs[2] = h_vs[1];
      h_rgb[1] = h_rgb[0]; h_hs[1] = h_hs[0]; h_vs[1] = h_vs[0];
      h_rgb[0] = exp_rgb(x, y); h_hs[0] = hs; h_vs[0] = vs;
      if (x == 0 && y == 480) model_frame(mv, d);
      repeat (2) @(negedge clk);
      bus.p_tick = 1'b0;
      repeat (2) @(negedge clk);
      check("rgb", bus.rgb, h_rgb[2]);
      check("hs_out", 12'(bus.hs_out), 12'(h_hs[2]));
      check("vs_out", 12'(bus.vs_out), 12'(h_vs[2]));
   endtask

   task automatic frame(input bit mv, input int d);
      pixel(0, 480, 1'b1, 1'b1, mv, d);
   endtask

   task automatic blank2();
      pixel(700, 500, 1'b1, 1'b1, 1'b0, 0);
      pixel(700, 500, 1'b1, 1'b1, 1'b0, 0);
   endtask

   initial begin
      int x, y, r;
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      bus.p_tick = 1'b0; bus.p_x = 10'd0; bus.p_y = 10'd0;
      bus.hs_in = 1'b1; bus.vs_in = 1'b1; bus.move_en = 1'b0; bus.dir_in = 2'b00;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("reset_rgb", bus.rgb, 12'h000);
      check("reset_hs", 12'(bus.hs_out), 12'h001);
      check("reset_vs", 12'(bus.vs_out), 12'h001);

      // static shape at the start position, mouth open facing right
      pixel(320, 240, 1'b1, 1'b1, 1'b1, 3);
      pixel(311, 240, 1'b1, 1'b1, 1'b0, 0);
      pixel(312, 232, 1'b1, 1'b1, 1'b0, 0);
      pixel(325, 241, 1'b1, 1'b1, 1'b0, 0);
      pixel(700, 240, 1'b1, 1'b1, 1'b0, 0);
      blank2();

      // sync alignment: 2-pixel hs pulse then 1-pixel vs pulse
      pixel(700, 500, 1'b0, 1'b1, 1'b0, 0);
      pixel(700, 500, 1'b0, 1'b1, 1'b0, 0);
      pixel(700, 500, 1'b1, 1'b0, 1'b0, 0);
      blank2();
      blank2();

      // one step right, then the rest of an animation phase closes the mouth
      frame(1'b1, 0);
      pixel(322, 240, 1'b1, 1'b1, 1'b0, 0);
      pixel(314, 240, 1'b1, 1'b1, 1'b0, 0);
      for (int i = 0; i < 7; i++) frame(1'b1, 0);
      pixel(341, 241, 1'b1, 1'b1, 1'b0, 0);
      pixel(336, 240, 1'b1, 1'b1, 1'b0, 0);
      blank2();

      // idle frames with heading changes: mouth and position hold
      for (int i = 0; i < 10; i++) frame(1'b0, i % 4);
      frame(1'b0, 2);
      pixel(336, 235, 1'b1, 1'b1, 1'b0, 0);
      pixel(336, 245, 1'b1, 1'b1, 1'b0, 0);
      blank2();

      // walls: left, right, up, down
      for (int i = 0; i < 200; i++) frame(1'b1, 1);
      pixel(8, m_y + 8, 1'b1, 1'b1, 1'b0, 0);
      pixel(3, m_y + 8, 1'b1, 1'b1, 1'b0, 0);
      pixel(16, m_y + 8, 1'b1, 1'b1, 1'b0, 0);
      for (int i = 0; i < 340; i++) frame(1'b1, 0);
      pixel(632, m_y + 8, 1'b1, 1'b1, 1'b0, 0);
      pixel(639, m_y + 8, 1'b1, 1'b1, 1'b0, 0);
      pixel(623, m_y + 8, 1'b1, 1'b1, 1'b0, 0);
      for (int i = 0; i < 130; i++) frame(1'b1, 2);
      pixel(632, 2, 1'b1, 1'b1, 1'b0, 0);
      pixel(632, 8, 1'b1, 1'b1, 1'b0, 0);
      for (int i = 0; i < 250; i++) frame(1'b1, 3);
      pixel(632, 479, 1'b1, 1'b1, 1'b0, 0);
      pixel(632, 472, 1'b1, 1'b1, 1'b0, 0);
      blank2();

      // randomized mix of pixels around the sprite, blanking pixels and frame events
      for (int i = 0; i < 500; i++) begin
         r = $urandom_range(0, 11);
         if (r == 0) begin
            frame(($urandom_range(0, 3) != 0), $urandom_range(0, 3));
         end else begin
            if (r == 1) begin
               x = $urandom_range(0, 1023);
               y = $urandom_range(0, 1023);
            end else begin
               x = m_x + $urandom_range(0, 23) - 4;
               y = m_y + $urandom_range(0, 23) - 4;
               x = (x < 0) ? 0 : x;
               y = (y < 0) ? 0 : y;
            end
            pixel(x, y, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3));
         end
      end

      // mid-frame reset with non-idle pipeline contents
      pixel(m_x + 8, m_y + 8, 1'b0, 1'b0, 1'b0, 0);
      pixel(m_x + 8, 100, 1'b0, 1'b0, 1'b0, 0);
      pixel(m_x + 8, m_y + 8, 1'b0, 1'b0, 1'b0, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      check("midrst_rgb", bus.rgb, 12'h000);
      check("midrst_hs", 12'(bus.hs_out), 12'h001);
      check("midrst_vs", 12'(bus.vs_out), 12'h001);
      pixel(320, 100, 1'b1, 1'b1, 1'b0, 0);
      pixel(320, 240, 1'b0, 1'b1, 1'b0, 0);
      pixel(325, 241, 1'b1, 1'b1, 1'b0, 0);
      pixel(313, 240, 1'b1, 1'b0, 1'b0, 0);
      blank2();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
